alarme_multizona: RTL and testbench
===================================

ALARME_MULTIZONA -- requirements
Module: alarme_multizona

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL accept parameter N_ZONES, default 4: number of sensor zones, 1..16.
REQ-003 The block SHALL accept parameter ENTRY_DELAY, default 8: cycles allowed in ENTRADA before DISPARO, >=1.
REQ-004 The block SHALL accept parameter SIREN_TIMEOUT, default 64: cycles in DISPARO before SILENCIO, >=1.
REQ-005 The block SHALL accept parameter LED_ALERT_DIV, default 4: LED half-period in cycles in ALERTA and SILENCIO, >=1.
REQ-006 The block SHALL accept parameter LED_TRIG_DIV, default 1: LED half-period in cycles in ENTRADA and DISPARO, >=1.
REQ-007 The block SHALL accept parameter SIREN_DIV, default 5: siren half-period in cycles in DISPARO, >=1.
REQ-008 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-009 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 The block SHALL have port cr, input, 1 bit: arm/disarm key, level; only its 0->1 edge acts.
REQ-011 The block SHALL have port zones, input, N_ZONES bits: sensor levels, 1 = violated.
REQ-012 The block SHALL have port zone_en, input, N_ZONES bits: 0 masks the zone (bypass).
REQ-013 The block SHALL have port zone_delayed, input, N_ZONES bits: 1 = entry-delay zone, 0 = immediate zone.
REQ-014 The block SHALL have port sirene, output, 1 bit: siren drive.
REQ-015 The block SHALL have port led, output, 1 bit: status LED.
REQ-016 The block SHALL have port estado, output, 3 bits: current state code.
REQ-017 The block SHALL have port zone_mem, output, N_ZONES bits: latched violated zones (alarm memory).

Function
REQ-018 The states SHALL be STANDBY=0, ALERTA=1, ENTRADA=2, DISPARO=3 and SILENCIO=4, held in registers.
REQ-019 The block SHALL register cr once and form cr_rise = cr & ~cr_q; a held cr SHALL act once only.
REQ-020 The block SHALL derive hit = zones & zone_en, imm = hit & ~zone_delayed and dly = hit & zone_delayed.
REQ-021 In STANDBY, zones SHALL be ignored, and cr_rise SHALL go to ALERTA and clear zone_mem on the same edge.
REQ-022 In ALERTA, the priority SHALL be: cr_rise -> STANDBY; else imm!=0 -> DISPARO; else dly!=0 -> ENTRADA; else stay.
REQ-023 In ENTRADA, the priority SHALL be: cr_rise -> STANDBY; else imm!=0 -> DISPARO; else after ENTRY_DELAY cycles in ENTRADA -> DISPARO.
REQ-024 In DISPARO, cr_rise SHALL go to STANDBY; otherwise, after SIREN_TIMEOUT cycles in DISPARO, the block SHALL go to SILENCIO.
REQ-025 In SILENCIO, the priority SHALL be: cr_rise -> STANDBY; else any hit bit not set in zone_mem -> DISPARO, with a fresh timeout.
REQ-026 In every state except STANDBY, zone_mem SHALL OR in hit each cycle; zone_mem SHALL hold its value in STANDBY.
REQ-027 Each state-residency counter SHALL clear on state entry, be $clog2(limit+1) bits wide and never wrap.
REQ-028 sirene SHALL be 1 on the first DISPARO cycle and toggle every SIREN_DIV cycles in DISPARO; it SHALL be 0 in all other states.
REQ-029 led SHALL be constant 1 in STANDBY.
REQ-030 In each other state, led SHALL start at 0 on state entry and toggle at the divider for that state.
REQ-031 All outputs SHALL be registered and SHALL change on the same edge as estado.
REQ-032 When cr_rise and a zone event occur in the same cycle, cr_rise SHALL win.

Reset
REQ-033 Reset SHALL force estado=STANDBY, sirene=0, led=1 and zone_mem=0, and SHALL clear cr_q and all counters.
REQ-034 Reset SHALL have priority over all inputs and SHALL abort any state mid-count.
REQ-035 On the cycle after reset deasserts with cr already high, no arm edge SHALL be seen.

Structure
REQ-036 The state enum, state codes and parameter defaults SHALL live in the shared package alarme_pkg.
REQ-037 A toggle generator sub-module blink_div SHALL be used, with parameter DIV and ports clk, reset, restart, en, init, out.
REQ-038 blink_div SHALL be instantiated once for led and once for sirene.

Verification
REQ-039 Arm test: with defaults, a cr pulse in STANDBY -> estado=1 next edge; led toggles every 4 cycles; sirene=0.
REQ-040 Entry-delay test: zone 0 delayed and violated in ALERTA -> ENTRADA for 8 cycles, then DISPARO; a cr pulse at cycle 5 -> STANDBY, sirene stays 0.
REQ-041 Immediate-zone test: zone 2 immediate and violated during ENTRADA -> DISPARO next edge; sirene=1 for 5 cycles, then 0 for 5.
REQ-042 Silence/re-trigger test: 64 cycles in DISPARO -> SILENCIO with sirene=0; zone 1 violated with zone_mem=4'b0001 -> DISPARO.
REQ-043 Masking/priority test: a violated zone with zone_en=0 -> no change; cr_rise and an imm hit in the same cycle -> STANDBY.
REQ-044 Reset test: reset in DISPARO -> estado=0, sirene=0, led=1, zone_mem=0; cr held high through reset release -> remains STANDBY.

Source files
------------

// File: rtl/alarme_pkg.sv
// Shared types and parameter defaults for the multizone alarm controller.
package alarme_pkg;

  typedef enum logic [2:0] {
    StStandby  = 3'd0,
    StAlerta   = 3'd1,
    StEntrada  = 3'd2,
    StDisparo  = 3'd3,
    StSilencio = 3'd4
  } estado_e;

  localparam int unsigned NZonesDef       = 4;
  localparam int unsigned EntryDelayDef   = 8;
  localparam int unsigned SirenTimeoutDef = 64;
  localparam int unsigned LedAlertDivDef  = 4;
  localparam int unsigned LedTrigDivDef   = 1;
  localparam int unsigned SirenDivDef     = 5;

endpackage

// File: rtl/blink_div.sv
// Registered toggle generator: holds its output for DIV enabled cycles, then toggles.
module blink_div #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  input  logic init,
  output logic out
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          out_q;

  // Reset loads init too, so the parent decides the post-reset level.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
      out_q <= init;
    end else if (en) begin
      if (cnt_q == Last) begin
        cnt_q <= '0;
        out_q <= ~out_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out = out_q;

endmodule

// File: rtl/alarme_multizona.sv
// Multizone burglar alarm: arm/disarm key, entry delay, siren timeout and alarm memory.
module alarme_multizona
  import alarme_pkg::*;
#(
  parameter int unsigned N_ZONES       = NZonesDef,
  parameter int unsigned ENTRY_DELAY   = EntryDelayDef,
  parameter int unsigned SIREN_TIMEOUT = SirenTimeoutDef,
  parameter int unsigned LED_ALERT_DIV = LedAlertDivDef,
  parameter int unsigned LED_TRIG_DIV  = LedTrigDivDef,
  parameter int unsigned SIREN_DIV     = SirenDivDef
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cr,
  input  logic [N_ZONES-1:0] zones,
  input  logic [N_ZONES-1:0] zone_en,
  input  logic [N_ZONES-1:0] zone_delayed,
  output logic               sirene,
  output logic               led,
  output logic [2:0]         estado,
  output logic [N_ZONES-1:0] zone_mem
);

  localparam int unsigned EntryW = $clog2(ENTRY_DELAY + 1);
  localparam int unsigned SirenW = $clog2(SIREN_TIMEOUT + 1);
  localparam int unsigned LedMax = (LED_ALERT_DIV > LED_TRIG_DIV) ? LED_ALERT_DIV : LED_TRIG_DIV;
  localparam int unsigned LedW   = $clog2(LedMax + 1);

  localparam logic [EntryW-1:0] EntryLast = EntryW'(ENTRY_DELAY - 1);
  localparam logic [EntryW-1:0] EntryMax  = EntryW'(ENTRY_DELAY);
  localparam logic [SirenW-1:0] SirenLast = SirenW'(SIREN_TIMEOUT - 1);
  localparam logic [SirenW-1:0] SirenMax  = SirenW'(SIREN_TIMEOUT);
  localparam logic [LedW-1:0]   LedAlertLast = LedW'(LED_ALERT_DIV - 1);
  localparam logic [LedW-1:0]   LedTrigLast  = LedW'(LED_TRIG_DIV - 1);

  estado_e             state_q, state_d;
  logic                cr_q, reset_q, cr_rise;
  logic [N_ZONES-1:0]  hit, imm, dly, zone_mem_q, zone_mem_d;
  logic [EntryW-1:0]   entry_cnt_q;
  logic [SirenW-1:0]   siren_cnt_q;
  logic [LedW-1:0]     led_cnt_q, led_last;
  logic                changed, led_tick, led_init, sir_init, sir_en;

  // reset_q masks the first post-reset cycle so a key held through reset is not an arm edge.
  assign cr_rise = cr & ~cr_q & ~reset_q;
  assign hit     = zones & zone_en;
  assign imm     = hit & ~zone_delayed;
  assign dly     = hit & zone_delayed;
  assign changed = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StStandby;
      cr_q        <= 1'b0;
      reset_q     <= 1'b1;
      zone_mem_q  <= '0;
      entry_cnt_q <= '0;
      siren_cnt_q <= '0;
      led_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cr_q       <= cr;
      reset_q    <= 1'b0;
      zone_mem_q <= zone_mem_d;
      if (changed) begin
        entry_cnt_q <= '0;
      end else if (state_q == StEntrada && entry_cnt_q != EntryMax) begin
        entry_cnt_q <= entry_cnt_q + 1'b1;
      end
      if (changed) begin
        siren_cnt_q <= '0;
      end else if (state_q == StDisparo && siren_cnt_q != SirenMax) begin
        siren_cnt_q <= siren_cnt_q + 1'b1;
      end
      if (changed) begin
        led_cnt_q <= '0;
      end else if (state_q != StStandby) begin
        led_cnt_q <= led_tick ? '0 : led_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StStandby: if (cr_rise) state_d = StAlerta;
      StAlerta: begin
        if (cr_rise)        state_d = StStandby;
        else if (|imm)      state_d = StDisparo;
        else if (|dly)      state_d = StEntrada;
      end
      StEntrada: begin
        if (cr_rise)                      state_d = StStandby;
        else if (|imm)                    state_d = StDisparo;
        else if (entry_cnt_q == EntryLast) state_d = StDisparo;
      end
      StDisparo: begin
        if (cr_rise)                      state_d = StStandby;
        else if (siren_cnt_q == SirenLast) state_d = StSilencio;
      end
      StSilencio: begin
        if (cr_rise)                          state_d = StStandby;
        else if ((hit & ~zone_mem_q) != '0)   state_d = StDisparo;
      end
      default: state_d = StStandby;
    endcase
  end

  always_comb begin
    zone_mem_d = zone_mem_q | hit;
    if (state_q == StStandby) zone_mem_d = cr_rise ? '0 : zone_mem_q;
  end

  always_comb begin
    led_last = (state_q == StAlerta || state_q == StSilencio) ? LedAlertLast : LedTrigLast;
    led_tick = (state_q != StStandby) && (led_cnt_q == led_last);
    led_init = reset || (state_d == StStandby);
    sir_init = !reset && (state_d == StDisparo);
    sir_en   = (state_q == StDisparo);
  end

  // The per-state LED rate comes from led_cnt_q; the LED toggler just flips on each tick.
  blink_div #(
    .DIV(1)
  ) u_led_div (
    .clk    (clk),
    .reset  (reset),
    .restart(changed),
    .en     (led_tick),
    .init   (led_init),
    .out    (led)
  );

  blink_div #(
    .DIV(SIREN_DIV)
  ) u_sir_div (
    .clk    (clk),
    .reset  (reset),
    .restart(changed),
    .en     (sir_en),
    .init   (sir_init),
    .out    (sirene)
  );

  assign estado   = state_q;
  assign zone_mem = zone_mem_q;

endmodule

// File: tb/tb_alarme_multizona.sv
// Scoreboard bench for alarme_multizona: directed steps push expectations, a monitor checks them.
module tb_alarme_multizona;

  logic       clk = 1'b0;
  logic       reset, cr;
  logic [3:0] zones, zone_en, zone_delayed;
  logic       sirene, led;
  logic [2:0] estado;
  logic [3:0] zone_mem;

  typedef struct {
    int est;
    int sir;
    int led;
    int mem;
    int id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  alarme_multizona dut (
    .clk         (clk),
    .reset       (reset),
    .cr          (cr),
    .zones       (zones),
    .zone_en     (zone_en),
    .zone_delayed(zone_delayed),
    .sirene      (sirene),
    .led         (led),
    .estado      (estado),
    .zone_mem    (zone_mem)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int id, int act, int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, id, act, exp);
    end
  endfunction

  // Inputs applied at negedge; the expectation describes outputs after the next posedge.
  task automatic step(input logic r, input logic c, input logic [3:0] z, input logic [3:0] en,
                      input int e_est, input int e_sir, input int e_led, input int e_mem);
    exp_t e;
    @(negedge clk);
    reset   = r;
    cr      = c;
    zones   = z;
    zone_en = en;
    step_no++;
    e = '{e_est, e_sir, e_led, e_mem, step_no};
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("estado", e.id, int'(estado), e.est);
        chk("sirene", e.id, int'(sirene), e.sir);
        chk("led", e.id, int'(led), e.led);
        chk("zone_mem", e.id, int'(zone_mem), e.mem);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cr = 1'b0; zones = 4'h0; zone_en = 4'hF; zone_delayed = 4'b0001;

    // Reset, then STANDBY ignores zones
    repeat (3) step(1, 0, 4'h0, 4'hF, 0, 0, 1, 0);
    step(0, 0, 4'hF, 4'hF, 0, 0, 1, 0);

    // Arm; held key acts once; LED blinks with half-period 4
    step(0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    step(0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    for (int k = 2; k <= 8; k++) step(0, 0, 4'h0, 4'hF, 1, 0, (k / 4) % 2, 0);

    // Masked zone 2 has no effect
    for (int k = 9; k <= 10; k++) step(0, 0, 4'b0100, 4'b1011, 1, 0, (k / 4) % 2, 0);

    // Delayed zone -> ENTRADA, disarm at cycle 5
    step(0, 0, 4'b0001, 4'hF, 2, 0, 0, 1);
    for (int k = 1; k <= 4; k++) step(0, 0, 4'h0, 4'hF, 2, 0, k % 2, 1);
    step(0, 1, 4'h0, 4'hF, 0, 0, 1, 1);
    step(0, 0, 4'h0, 4'hF, 0, 0, 1, 1);

    // Full entry delay -> DISPARO -> SILENCIO -> re-trigger on new zone
    step(0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    step(0, 0, 4'b0001, 4'hF, 2, 0, 0, 1);
    for (int k = 1; k <= 7; k++) step(0, 0, 4'h0, 4'hF, 2, 0, k % 2, 1);
    step(0, 0, 4'h0, 4'hF, 3, 1, 0, 1);
    for (int k = 1; k <= 63; k++)
      step(0, 0, 4'h0, 4'hF, 3, ((k / 5) % 2 == 0) ? 1 : 0, k % 2, 1);
    step(0, 0, 4'h0, 4'hF, 4, 0, 0, 1);
    step(0, 0, 4'b0001, 4'hF, 4, 0, 0, 1);
    step(0, 0, 4'h0, 4'hF, 4, 0, 0, 1);
    step(0, 0, 4'b0010, 4'hF, 3, 1, 0, 3);
    for (int k = 1; k <= 6; k++) step(0, 0, 4'h0, 4'hF, 3, (k < 5) ? 1 : 0, k % 2, 3);
    step(0, 1, 4'h0, 4'hF, 0, 0, 1, 3);
    step(0, 0, 4'h0, 4'hF, 0, 0, 1, 3);

    // Immediate zone during ENTRADA -> DISPARO, siren 5 on / 5 off
    step(0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    step(0, 0, 4'b0001, 4'hF, 2, 0, 0, 1);
    for (int k = 1; k <= 2; k++) step(0, 0, 4'h0, 4'hF, 2, 0, k % 2, 1);
    step(0, 0, 4'b0100, 4'hF, 3, 1, 0, 5);
    for (int k = 1; k <= 10; k++)
      step(0, 0, 4'h0, 4'hF, 3, ((k / 5) % 2 == 0) ? 1 : 0, k % 2, 5);

    // Disarm wins over a simultaneous immediate hit in ALERTA
    step(0, 1, 4'h0, 4'hF, 0, 0, 1, 5);
    step(0, 0, 4'h0, 4'hF, 0, 0, 1, 5);
    step(0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    step(0, 0, 4'h0, 4'hF, 1, 0, 0, 0);
    step(0, 1, 4'b0100, 4'hF, 0, 0, 1, 4);

    // Reset in DISPARO; key held through reset release does not arm
    step(0, 0, 4'h0, 4'hF, 0, 0, 1, 4);
    step(0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    step(0, 0, 4'b0100, 4'hF, 3, 1, 0, 4);
    step(0, 0, 4'h0, 4'hF, 3, 1, 1, 4);
    step(1, 1, 4'h0, 4'hF, 0, 0, 1, 0);
    step(1, 1, 4'h0, 4'hF, 0, 0, 1, 0);
    step(0, 1, 4'h0, 4'hF, 0, 0, 1, 0);
    step(0, 1, 4'h0, 4'hF, 0, 0, 1, 0);
    step(0, 0, 4'h0, 4'hF, 0, 0, 1, 0);
    step(0, 1, 4'h0, 4'hF, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
